kbd_sim_bench: RTL and testbench

//  Keyboard-matrix scanner with debounce and key-event reporting, wrapped as a

---
 rtl/kbd_sim_bench.sv | 207 ++++++++++++++++++++
 tb/tb_kbd_sim_bench.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/kbd_sim_bench.sv
`timescale 1ns/1ps
// Keyboard-matrix scanner with per-key debounce, ordered press/release event reporting and a
// terminating-key pass/fail flag. Define KBD_DEBOUNCE_EN to enable frame-based debouncing.
module kbd_sim_bench #(
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned DONE_ROW        = 2,
  parameter int unsigned DONE_COL        = 1,
  parameter int unsigned EXPECT_EVENTS   = 7
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        lpclk,
  input  logic [8:0]  kbd_row,
  output logic [9:0]  kbd_col,
  output logic        sim_success,
  output logic        sim_done,
  output logic [31:0] sim_report
);

  localparam int unsigned NumRows = 9;
  localparam int unsigned NumCols = 10;
  localparam int unsigned NumKeys = NumRows * NumCols;

  // Synchronisers and tick detection
  logic       lp_s1_q, lp_s2_q, lp_s3_q;
  logic [8:0] row_s1_q, row_s2_q;
  logic       tick;
  logic       frame_end;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lp_s1_q  <= 1'b0;
      lp_s2_q  <= 1'b0;
      lp_s3_q  <= 1'b0;
      row_s1_q <= '0;
      row_s2_q <= '0;
    end else begin
      lp_s1_q  <= lpclk;
      lp_s2_q  <= lp_s1_q;
      lp_s3_q  <= lp_s2_q;
      row_s1_q <= kbd_row;
      row_s2_q <= row_s1_q;
    end
  end

  assign tick = lp_s2_q & ~lp_s3_q;

  // Column scan
  logic [3:0] col_idx_q, col_idx_d;
  logic [9:0] kbd_col_q, kbd_col_d;

  assign frame_end = tick && (col_idx_q == 4'd9);

  always_comb begin
    col_idx_d = col_idx_q;
    kbd_col_d = kbd_col_q;
    if (tick) begin
      col_idx_d = frame_end ? 4'd0 : col_idx_q + 4'd1;
      kbd_col_d = 10'd1 << col_idx_d;
    end
  end

  // Raw matrix, key index = col * NumRows + row. At frame end raw_d holds the complete frame.
  logic [NumKeys-1:0] raw_q, raw_d;

  always_comb begin
    raw_d = raw_q;
    if (tick) begin
      for (int c = 0; c < int'(NumCols); c++) begin
        if (col_idx_q == 4'(c)) raw_d[c*NumRows +: NumRows] = row_s2_q;
      end
    end
  end

  logic [NumKeys-1:0] deb_frame;

`ifdef KBD_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_FRAMES - 1);

  logic [NumKeys-1:0]           prev_q, prev_d;
  logic [NumKeys-1:0]           deb_q, deb_d;
  logic [NumKeys-1:0][CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    prev_d = prev_q;
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    if (frame_end) begin
      prev_d = raw_d;
      for (int k = 0; k < int'(NumKeys); k++) begin
        if (raw_d[k] == prev_q[k]) begin
          cnt_d[k] = (cnt_q[k] == CntMax) ? CntMax : cnt_q[k] + 1'b1;
        end else begin
          cnt_d[k] = '0;
        end
        if (cnt_d[k] == CntMax) deb_d[k] = raw_d[k];
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      deb_q  <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_frame = deb_d;
`else
  assign deb_frame = raw_d;
`endif

  // Event selection: lowest key index wins, i.e. col-major then row order
  logic [NumKeys-1:0] rep_q, rep_d;
  logic [NumKeys-1:0] diff;
  logic [NumKeys-1:0] ev_sel;
  logic               ev_found;
  logic               ev_press;
  logic [3:0]         ev_row;
  logic [3:0]         ev_col;

  assign diff = deb_frame ^ rep_q;

  always_comb begin
    ev_found = 1'b0;
    ev_press = 1'b0;
    ev_row   = '0;
    ev_col   = '0;
    ev_sel   = '0;
    for (int c = int'(NumCols) - 1; c >= 0; c--) begin
      for (int r = int'(NumRows) - 1; r >= 0; r--) begin
        if (diff[c*NumRows+r]) begin
          ev_found                = 1'b1;
          ev_press                = deb_frame[c*NumRows+r];
          ev_row                  = 4'(r);
          ev_col                  = 4'(c);
          ev_sel                  = '0;
          ev_sel[c*NumRows+r]     = 1'b1;
        end
      end
    end
  end

  // Event counter, report and termination flags
  logic [15:0] ev_cnt_q, ev_cnt_d, ev_cnt_inc;
  logic [31:0] report_q, report_d;
  logic        done_q, done_d;
  logic        success_q, success_d;
  logic        do_event;
  logic        is_done_key;

  assign do_event    = frame_end && ev_found;
  assign ev_cnt_inc  = (ev_cnt_q == 16'hFFFF) ? ev_cnt_q : ev_cnt_q + 16'd1;
  assign is_done_key = ev_press && (ev_row == 4'(DONE_ROW)) && (ev_col == 4'(DONE_COL));

  always_comb begin
    rep_d     = rep_q;
    ev_cnt_d  = ev_cnt_q;
    report_d  = report_q;
    done_d    = done_q;
    success_d = success_q;
    if (do_event) begin
      rep_d    = rep_q ^ ev_sel;
      ev_cnt_d = ev_cnt_inc;
      report_d = {ev_cnt_inc, ev_press, 3'b000, ev_row, 4'b0000, ev_col};
      // Flags latch on the first terminating press only
      if (!done_q && is_done_key) begin
        done_d    = 1'b1;
        success_d = (ev_cnt_inc == 16'(EXPECT_EVENTS));
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      col_idx_q <= '0;
      kbd_col_q <= 10'd1;
      raw_q     <= '0;
      rep_q     <= '0;
      ev_cnt_q  <= '0;
      report_q  <= '0;
      done_q    <= 1'b0;
      success_q <= 1'b0;
    end else begin
      col_idx_q <= col_idx_d;
      kbd_col_q <= kbd_col_d;
      raw_q     <= raw_d;
      rep_q     <= rep_d;
      ev_cnt_q  <= ev_cnt_d;
      report_q  <= report_d;
      done_q    <= done_d;
      success_q <= success_d;
    end
  end

  assign kbd_col     = kbd_col_q;
  assign sim_done    = done_q;
  assign sim_success = success_q;
  assign sim_report  = report_q;

endmodule

// File: tb/tb_kbd_sim_bench.sv
`timescale 1ns/1ps
// Directed bench for kbd_sim_bench: a key-matrix model drives rows from the column strobe and a
// scoreboard queue holds the expected event reports in order.
module tb_kbd_sim_bench;

  localparam int unsigned DebFrames = 3;

  logic        refclk = 1'b0;
  logic        rst;
  logic        lpclk;
  logic [8:0]  kbd_row;
  logic [9:0]  kbd_col;
  logic        sim_success;
  logic        sim_done;
  logic [31:0] sim_report;

  logic [89:0] keys;
  logic [31:0] exp_q[$];
  logic [31:0] last_rep;
  int          checks = 0;
  int          errors = 0;

  kbd_sim_bench #(
    .DEBOUNCE_FRAMES(DebFrames),
    .DONE_ROW       (2),
    .DONE_COL       (1),
    .EXPECT_EVENTS  (9)
  ) u_dut (
    .refclk     (refclk),
    .rst        (rst),
    .lpclk      (lpclk),
    .kbd_row    (kbd_row),
    .kbd_col    (kbd_col),
    .sim_success(sim_success),
    .sim_done   (sim_done),
    .sim_report (sim_report)
  );

  always #5 refclk = ~refclk;

  always_comb begin
    kbd_row = '0;
    for (int c = 0; c < 10; c++) begin
      for (int r = 0; r < 9; r++) begin
        if (kbd_col[c] && keys[c*9+r]) kbd_row[r] = 1'b1;
      end
    end
  end

  function automatic logic [31:0] ev(int cnt, bit press, int row, int col);
    return {16'(cnt), press, 3'b000, 4'(row), 4'b0000, 4'(col)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One refclk cycle; any change of sim_report is a produced event checked against the queue
  task automatic cyc();
    @(negedge refclk);
    if (sim_report !== last_rep) begin
      if (exp_q.size() == 0) chk("unexpected_event", sim_report, last_rep);
      else chk("event", sim_report, exp_q.pop_front());
      last_rep = sim_report;
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      lpclk = 1'b1;
      repeat (4) cyc();
      lpclk = 1'b0;
      repeat (6) cyc();
    end
  endtask

  task automatic set_key(int row, int col, bit v);
    keys[col*9+row] = v;
  endtask

  initial begin
    rst      = 1'b1;
    lpclk    = 1'b0;
    keys     = '0;
    last_rep = '0;
    repeat (3) @(negedge refclk);
    chk("reset_col", 32'(kbd_col), 32'h001);
    chk("reset_done", 32'(sim_done), 32'd0);
    chk("reset_success", 32'(sim_success), 32'd0);
    chk("reset_report", sim_report, 32'd0);
    rst = 1'b0;
    repeat (2) cyc();

    // Column walk over one frame
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("col_walk", 32'(kbd_col), 32'(1 << ((i + 1) % 10)));
    end

    // Two keys on row 3, reported in column order
    set_key(3, 2, 1'b1);
    set_key(3, 4, 1'b1);
    exp_q.push_back(ev(1, 1'b1, 3, 2));
    exp_q.push_back(ev(2, 1'b1, 3, 4));
    tick(300);
    chk("press_pair_report", sim_report, ev(2, 1'b1, 3, 4));
    chk("press_pair_drained", 32'(exp_q.size()), 32'd0);

    set_key(3, 2, 1'b0);
    set_key(3, 4, 1'b0);
    exp_q.push_back(ev(3, 1'b0, 3, 2));
    exp_q.push_back(ev(4, 1'b0, 3, 4));
    tick(300);
    chk("count_after_release", 32'(sim_report[31:16]), 32'd4);

    set_key(3, 2, 1'b1);
    set_key(3, 4, 1'b1);
    exp_q.push_back(ev(5, 1'b1, 3, 2));
    exp_q.push_back(ev(6, 1'b1, 3, 4));
    tick(100);
    chk("count_after_repress", 32'(sim_report[31:16]), 32'd6);

    set_key(3, 2, 1'b0);
    set_key(3, 4, 1'b0);
    exp_q.push_back(ev(7, 1'b0, 3, 2));
    exp_q.push_back(ev(8, 1'b0, 3, 4));
    tick(400);
    chk("count_after_rerelease", 32'(sim_report[31:16]), 32'd8);
    chk("not_done_yet", 32'(sim_done), 32'd0);

    // Terminating key as the ninth event
    set_key(2, 1, 1'b1);
    exp_q.push_back(ev(9, 1'b1, 2, 1));
    tick(10 * (DebFrames + 1));
    chk("done_set", 32'(sim_done), 32'd1);
    chk("success_set", 32'(sim_success), 32'd1);
    chk("done_count", 32'(sim_report[31:16]), 32'd9);

    set_key(2, 1, 1'b0);
    exp_q.push_back(ev(10, 1'b0, 2, 1));
    tick(50);
    chk("done_sticky", 32'(sim_done), 32'd1);
    chk("success_sticky", 32'(sim_success), 32'd1);

    // One-frame glitch, frame aligned
    set_key(5, 7, 1'b1);
`ifndef KBD_DEBOUNCE_EN
    exp_q.push_back(ev(11, 1'b1, 5, 7));
    exp_q.push_back(ev(12, 1'b0, 5, 7));
`endif
    tick(10);
    set_key(5, 7, 1'b0);
    tick(60);
`ifdef KBD_DEBOUNCE_EN
    chk("glitch_count", 32'(sim_report[31:16]), 32'd10);
`else
    chk("glitch_count", 32'(sim_report[31:16]), 32'd12);
`endif
    chk("events_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame
    tick(5);
    chk("mid_scan_col", 32'(kbd_col), 32'h020);
    @(negedge refclk);
    rst = 1'b1;
    #1;
    chk("rst_col", 32'(kbd_col), 32'h001);
    chk("rst_done", 32'(sim_done), 32'd0);
    chk("rst_success", 32'(sim_success), 32'd0);
    chk("rst_report", sim_report, 32'd0);
    last_rep = '0;
    repeat (2) @(negedge refclk);
    rst = 1'b0;
    repeat (2) cyc();
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("col_walk_after_rst", 32'(kbd_col), 32'(1 << ((i + 1) % 10)));
    end
    chk("report_after_rst", sim_report, 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
